// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: IR contents in, bus/enable/ALU controls out.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        incPC;
  logic        MDR_read;
  logic        e_PC;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_HI;
  logic        e_LO;
  logic        e_MDR;
  logic        e_MAR;
  logic        e_GP;
  logic [3:0]  GP_addr;
  logic [4:0]  BusDataSelect;
  logic [3:0]  ALU_op;

  modport master (
    input  ir,
    output incPC, MDR_read, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
    output GP_addr, BusDataSelect, ALU_op
  );

  modport slave (
    output ir,
    input  incPC, MDR_read, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
    input  GP_addr, BusDataSelect, ALU_op
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control unit: fetch (T0-T2) and execute (T3-T6) sequencing for register-format ALU
// instructions, IR decode to datapath controls, and a retired-instruction counter.
module control_sequencer #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               run,
  control_sequencer_if.master ctrl,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned ST_W  = 4;
  localparam int unsigned SEL_W = 5;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [SEL_W-1:0] SEL_ZHI = SEL_W'(18);
  localparam logic [SEL_W-1:0] SEL_ZLO = SEL_W'(19);
  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(20);
  localparam logic [SEL_W-1:0] SEL_MDR = SEL_W'(21);

  logic [ST_W-1:0] state, state_nxt;
  logic [4:0]      op;
  logic [3:0]      ra, rb, rc;
  logic [3:0]      alu_map;
  logic            op_legal, op_long, op_unary;
  logic            unused_ir;

  assign op        = ctrl.ir[31:27];
  assign ra        = ctrl.ir[26:23];
  assign rb        = ctrl.ir[22:19];
  assign rc        = ctrl.ir[18:15];
  assign unused_ir = ^ctrl.ir[14:0];

  // Opcode decode: ALU code, legality, two-cycle writeback (MUL/DIV) and single-operand ops
  always_comb begin
    alu_map  = 4'd0;
    op_legal = 1'b1;
    op_long  = 1'b0;
    op_unary = 1'b0;
    case (op)
      5'b00000: alu_map = 4'd0;
      5'b00001: alu_map = 4'd1;
      5'b00010: alu_map = 4'd2;
      5'b00011: alu_map = 4'd3;
      5'b00100: alu_map = 4'd4;
      5'b00101: alu_map = 4'd5;
      5'b00110: alu_map = 4'd6;
      5'b00111: alu_map = 4'd7;
      5'b01000: alu_map = 4'd8;
      5'b01111: begin alu_map = 4'd9;  op_long  = 1'b1; end
      5'b10000: begin alu_map = 4'd10; op_long  = 1'b1; end
      5'b10001: begin alu_map = 4'd11; op_unary = 1'b1; end
      5'b10010: begin alu_map = 4'd12; op_unary = 1'b1; end
      default:  op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (clear)     instr_count <= '0;
    else if (done) instr_count <= instr_count + COUNT_W'(1);
  end

  // Next state and Moore outputs
  always_comb begin
    state_nxt          = state;
    ctrl.incPC         = 1'b0;
    ctrl.MDR_read      = 1'b0;
    ctrl.e_PC          = 1'b0;
    ctrl.e_IR          = 1'b0;
    ctrl.e_Y           = 1'b0;
    ctrl.e_Z           = 1'b0;
    ctrl.e_HI          = 1'b0;
    ctrl.e_LO          = 1'b0;
    ctrl.e_MDR         = 1'b0;
    ctrl.e_MAR         = 1'b0;
    ctrl.e_GP          = 1'b0;
    ctrl.GP_addr       = 4'd0;
    ctrl.BusDataSelect = '0;
    ctrl.ALU_op        = 4'd0;
    busy               = (state != S_IDLE) && (state != S_HALT);
    done               = 1'b0;
    illegal            = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0: begin
        ctrl.BusDataSelect = SEL_PC;
        ctrl.e_MAR         = 1'b1;
        ctrl.incPC         = 1'b1;
        ctrl.e_Z           = 1'b1;
        state_nxt          = S_T1;
      end
      S_T1: begin
        ctrl.BusDataSelect = SEL_ZLO;
        ctrl.e_PC          = 1'b1;
        ctrl.MDR_read      = 1'b1;
        ctrl.e_MDR         = 1'b1;
        state_nxt          = S_T2;
      end
      S_T2: begin
        ctrl.BusDataSelect = SEL_MDR;
        ctrl.e_IR          = 1'b1;
        state_nxt          = S_T3;
      end
      S_T3: begin
        if (!op_legal) begin
          state_nxt = S_HALT;
        end else begin
          ctrl.BusDataSelect = {1'b0, rb};
          ctrl.e_Y           = 1'b1;
          state_nxt          = S_T4;
        end
      end
      S_T4: begin
        ctrl.ALU_op        = alu_map;
        ctrl.e_Z           = 1'b1;
        ctrl.BusDataSelect = op_unary ? {1'b0, rb} : {1'b0, rc};
        state_nxt          = S_T5;
      end
      S_T5: begin
        ctrl.BusDataSelect = SEL_ZLO;
        if (op_long) begin
          ctrl.e_LO = 1'b1;
          state_nxt = S_T6;
        end else begin
          ctrl.GP_addr = ra;
          ctrl.e_GP    = 1'b1;
          done         = 1'b1;
          state_nxt    = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        ctrl.BusDataSelect = SEL_ZHI;
        ctrl.e_HI          = 1'b1;
        done               = 1'b1;
        state_nxt          = run ? S_T0 : S_IDLE;
      end
      S_HALT: illegal = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control vectors queued by the
// stimulus, popped and compared by a negedge monitor. A 3-bit-counter copy exercises wrap.
module tb_control_sequencer;

  typedef logic [45:0] vec_t;

  localparam logic [10:0] EN_INC  = 11'h400;
  localparam logic [10:0] EN_MDRR = 11'h200;
  localparam logic [10:0] EN_PC   = 11'h100;
  localparam logic [10:0] EN_IR   = 11'h080;
  localparam logic [10:0] EN_Y    = 11'h040;
  localparam logic [10:0] EN_Z    = 11'h020;
  localparam logic [10:0] EN_HI   = 11'h010;
  localparam logic [10:0] EN_LO   = 11'h008;
  localparam logic [10:0] EN_MDR  = 11'h004;
  localparam logic [10:0] EN_MAR  = 11'h002;
  localparam logic [10:0] EN_GP   = 11'h001;
  localparam logic [2:0]  F_B = 3'b100;
  localparam logic [2:0]  F_D = 3'b010;
  localparam logic [2:0]  F_I = 3'b001;

  localparam logic [31:0] IR_NEG = 32'h8A800000;
  localparam logic [31:0] IR_ADD = 32'h011A0000;
  localparam logic [31:0] IR_MUL = 32'h78090000;
  localparam logic [31:0] IR_ILL = 32'hF8000000;

  logic        clock;
  logic        clear;
  logic        run;
  logic        busy, done, illegal;
  logic [15:0] instr_count;
  logic        busy_n, done_n, illegal_n;
  logic [2:0]  cnt_n;

  control_sequencer_if cif ();
  control_sequencer_if cif_n ();

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ctrl(cif),
    .busy(busy), .done(done), .illegal(illegal), .instr_count(instr_count)
  );

  control_sequencer #(.COUNT_W(3)) dut_n (
    .clock(clock), .clear(clear), .run(run), .ctrl(cif_n),
    .busy(busy_n), .done(done_n), .illegal(illegal_n), .instr_count(cnt_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic vec_t mk(input logic [10:0] en, input logic [3:0] ga, input logic [4:0] sel,
                              input logic [3:0] alu, input logic [2:0] bdi, input logic [15:0] cnt);
    return {en, ga, sel, alu, bdi, cnt, cnt[2:0]};
  endfunction

  function automatic vec_t v_idle(input logic [15:0] c); return mk(11'h0, 4'd0, 5'd0, 4'd0, 3'b000, c); endfunction
  function automatic vec_t v_t0(input logic [15:0] c); return mk(EN_INC | EN_Z | EN_MAR, 4'd0, 5'd20, 4'd0, F_B, c); endfunction
  function automatic vec_t v_t1(input logic [15:0] c); return mk(EN_PC | EN_MDRR | EN_MDR, 4'd0, 5'd19, 4'd0, F_B, c); endfunction
  function automatic vec_t v_t2(input logic [15:0] c); return mk(EN_IR, 4'd0, 5'd21, 4'd0, F_B, c); endfunction
  function automatic vec_t v_t3(input logic [4:0] s, input logic [15:0] c); return mk(EN_Y, 4'd0, s, 4'd0, F_B, c); endfunction
  function automatic vec_t v_t3x(input logic [15:0] c); return mk(11'h0, 4'd0, 5'd0, 4'd0, F_B, c); endfunction
  function automatic vec_t v_t4(input logic [4:0] s, input logic [3:0] a, input logic [15:0] c); return mk(EN_Z, 4'd0, s, a, F_B, c); endfunction
  function automatic vec_t v_t5(input logic [3:0] ra, input logic [15:0] c); return mk(EN_GP, ra, 5'd19, 4'd0, F_B | F_D, c); endfunction
  function automatic vec_t v_t5m(input logic [15:0] c); return mk(EN_LO, 4'd0, 5'd19, 4'd0, F_B, c); endfunction
  function automatic vec_t v_t6(input logic [15:0] c); return mk(EN_HI, 4'd0, 5'd18, 4'd0, F_B | F_D, c); endfunction
  function automatic vec_t v_halt(input logic [15:0] c); return mk(11'h0, 4'd0, 5'd0, 4'd0, F_I, c); endfunction

  // One cycle: drive inputs just after the edge and queue the outputs expected in that cycle
  task automatic step(input logic r, input logic c, input logic [31:0] i, input vec_t e, input string n);
    @(posedge clock);
    #1;
    run      = r;
    clear    = c;
    cif.ir   = i;
    cif_n.ir = i;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  always @(negedge clock) begin
    vec_t  e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {cif.incPC, cif.MDR_read, cif.e_PC, cif.e_IR, cif.e_Y, cif.e_Z, cif.e_HI, cif.e_LO,
           cif.e_MDR, cif.e_MAR, cif.e_GP, cif.GP_addr, cif.BusDataSelect, cif.ALU_op,
           busy, done, illegal, instr_count, cnt_n};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
      end
    end
  end

  initial begin
    clear    = 1'b1;
    run      = 1'b1;
    cif.ir   = 32'h0;
    cif_n.ir = 32'h0;

    step(1, 1, 32'h0, v_idle(0), "reset_1");
    step(1, 1, 32'h0, v_idle(0), "reset_2");
    step(1, 0, IR_NEG, v_idle(0), "reset_idle");

    step(1, 0, IR_NEG, v_t0(0), "neg_t0");
    step(1, 0, IR_NEG, v_t1(0), "neg_t1");
    step(1, 0, IR_NEG, v_t2(0), "neg_t2");
    step(1, 0, IR_NEG, v_t3(5'd0, 0), "neg_t3");
    step(1, 0, IR_NEG, v_t4(5'd0, 4'b1011, 0), "neg_t4");
    step(1, 0, IR_NEG, v_t5(4'd5, 0), "neg_t5");

    step(1, 0, IR_ADD, v_t0(1), "add_t0");
    step(1, 0, IR_ADD, v_t1(1), "add_t1");
    step(1, 0, IR_ADD, v_t2(1), "add_t2");
    step(1, 0, IR_ADD, v_t3(5'd3, 1), "add_t3");
    step(1, 0, IR_ADD, v_t4(5'd4, 4'b0000, 1), "add_t4");
    step(1, 0, IR_ADD, v_t5(4'd2, 1), "add_t5");

    step(1, 0, IR_MUL, v_t0(2), "mul_t0");
    step(1, 0, IR_MUL, v_t1(2), "mul_t1");
    step(1, 0, IR_MUL, v_t2(2), "mul_t2");
    step(1, 0, IR_MUL, v_t3(5'd1, 2), "mul_t3");
    step(1, 0, IR_MUL, v_t4(5'd2, 4'b1001, 2), "mul_t4");
    step(1, 0, IR_MUL, v_t5m(2), "mul_t5");
    step(1, 0, IR_MUL, v_t6(2), "mul_t6");

    step(1, 0, IR_ADD, v_t0(3), "drop_t0");
    step(0, 0, IR_ADD, v_t1(3), "drop_t1");
    step(0, 0, IR_ADD, v_t2(3), "drop_t2");
    step(0, 0, IR_ADD, v_t3(5'd3, 3), "drop_t3");
    step(0, 0, IR_ADD, v_t4(5'd4, 4'b0000, 3), "drop_t4");
    step(0, 0, IR_ADD, v_t5(4'd2, 3), "drop_t5");
    step(0, 0, IR_ADD, v_idle(4), "drop_idle");
    step(1, 0, IR_ADD, v_idle(4), "drop_idle2");

    step(1, 0, IR_ADD, v_t0(4), "clr_t0");
    step(1, 0, IR_ADD, v_t1(4), "clr_t1");
    step(1, 0, IR_ADD, v_t2(4), "clr_t2");
    step(1, 0, IR_ADD, v_t3(5'd3, 4), "clr_t3");
    step(1, 1, IR_ADD, v_t4(5'd4, 4'b0000, 4), "clr_t4");
    step(0, 0, IR_ADD, v_idle(0), "clr_idle");
    step(1, 0, IR_ILL, v_idle(0), "clr_idle2");

    step(1, 0, IR_ILL, v_t0(0), "ill_t0");
    step(1, 0, IR_ILL, v_t1(0), "ill_t1");
    step(1, 0, IR_ILL, v_t2(0), "ill_t2");
    step(1, 0, IR_ILL, v_t3x(0), "ill_t3");
    step(1, 0, IR_ILL, v_halt(0), "halt_1");
    step(1, 0, IR_ILL, v_halt(0), "halt_2");
    step(1, 1, IR_ILL, v_halt(0), "halt_3");
    step(1, 0, IR_ADD, v_idle(0), "halt_clear");

    for (int k = 0; k < 8; k++) begin
      step(1, 0, IR_ADD, v_t0(16'(k)), "wrap_t0");
      step(1, 0, IR_ADD, v_t1(16'(k)), "wrap_t1");
      step(1, 0, IR_ADD, v_t2(16'(k)), "wrap_t2");
      step(1, 0, IR_ADD, v_t3(5'd3, 16'(k)), "wrap_t3");
      step(1, 0, IR_ADD, v_t4(5'd4, 4'b0000, 16'(k)), "wrap_t4");
      step(logic'(k < 7), 0, IR_ADD, v_t5(4'd2, 16'(k)), "wrap_t5");
    end
    step(0, 0, IR_ADD, v_idle(8), "wrap_idle");
    step(0, 0, IR_ADD, v_idle(8), "wrap_idle2");

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
